// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the multi-precision add sequencer: slice width, FSM state encoding
// and the signed-overflow rule.
package add_seq_ctrl_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Overflow when both operands share a sign and the result sign differs from it.
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

endpackage

// File: rtl/add_seq_ctrl_adder_cla16.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit groups with full lookahead
// across the groups and inside each group.
module adder_cla16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_bc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int k = 0; k < 4; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2]) |
                (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1]) |
                (&w_p[4*k+1 +: 3] & w_g[4*k]);
    end
  end

  assign w_bc[0] = i_cin;
  assign w_bc[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_bc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (&w_gp[1:0] & i_cin);
  assign w_bc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (&w_gp[2:1] & w_gg[0]) | (&w_gp[2:0] & i_cin);
  assign w_bc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (&w_gp[3:2] & w_gg[1]) |
                   (&w_gp[3:1] & w_gg[0]) | (&w_gp & i_cin);

  // Per-bit carries expanded from each group's incoming block carry.
  always_comb begin
    w_c = '0;
    for (int k = 0; k < 4; k++) begin
      w_c[4*k]   = w_bc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_bc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k]) | (w_p[4*k+1] & w_p[4*k] & w_bc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1]) |
                   (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]) |
                   (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_bc[k]);
    end
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_bc[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision adder sequencer: one 16-bit slice per cycle, LSW first, carry chained in a register.
// Optional build macro ADDSEQ_SAT_EN saturates the sum on signed overflow.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int DW    = WORDS * SLICE_W
) (
  input  logic          clk,
  input  logic          rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready (and rst is low);
  // out_valid and the result hold until out_ready, in_valid is only looked at while in_ready.
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sum,
  output logic          out_cout,
  output logic          out_ovf,
  output logic          busy
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [DW-1:0]       r_a_sh;
  logic [DW-1:0]       r_b_sh;
  logic                r_carry;
  logic                r_sign_a;
  logic                r_sign_b;
  logic [DW-1:0]       r_out_sum;
  logic                r_out_cout;
  logic                r_out_ovf;
  logic [SLICE_W-1:0]  w_slice_sum;
  logic                w_slice_cout;
  logic                w_last;
  logic                w_ovf;
  logic [DW-1:0]       w_raw_sum;
  logic [DW-1:0]       w_result;

  adder_cla16 u_adder (
    .i_a    (r_a_sh[SLICE_W-1:0]),
    .i_b    (r_b_sh[SLICE_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  assign w_last = (r_cnt == CW'(WORDS - 1));

  // Finished slices enter at the top of the sum register; on the last slice the
  // current adder output completes the full-width word.
  generate
    if (WORDS == 1) begin : g_single
      assign w_raw_sum = w_slice_sum;
    end else begin : g_multi
      logic [DW-SLICE_W-1:0] r_sum_sh;
      always_ff @(posedge clk) begin
        if (rst) r_sum_sh <= '0;
        else if (r_state == S_RUN) r_sum_sh <= w_raw_sum[DW-1:SLICE_W];
      end
      assign w_raw_sum = {w_slice_sum, r_sum_sh};
    end
  endgenerate

  assign w_ovf = signed_ovf(r_sign_a, r_sign_b, w_slice_sum[SLICE_W-1]);

`ifdef ADDSEQ_SAT_EN
  assign w_result = !w_ovf    ? w_raw_sum :
                    r_sign_a  ? {1'b1, {(DW-1){1'b0}}} :
                                {1'b0, {(DW-1){1'b1}}};
`else
  assign w_result = w_raw_sum;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_carry    <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a_sh   <= in_a;
          r_b_sh   <= in_b;
          r_carry  <= in_cin;
          r_cnt    <= '0;
          r_sign_a <= in_a[DW-1];
          r_sign_b <= in_b[DW-1];
        end
        S_RUN: begin
          r_a_sh  <= r_a_sh >> SLICE_W;
          r_b_sh  <= r_b_sh >> SLICE_W;
          r_carry <= w_slice_cout;
          if (w_last) begin
            r_out_sum  <= w_result;
            r_out_cout <= w_slice_cout;
            r_out_ovf  <= w_ovf;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: WORDS=4, 1 and 7 instances checked every cycle against a
// wide-arithmetic reference, plus directed cases with literal expected values.
module tb_add_seq_ctrl;

  localparam int NI = 3;
  localparam int MW = 112;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic          in_valid [NI];
  logic          out_ready[NI];
  logic          in_cin   [NI];
  logic [MW-1:0] in_a     [NI];
  logic [MW-1:0] in_b     [NI];
  logic          in_ready [NI];
  logic          out_valid[NI];
  logic          out_cout [NI];
  logic          out_ovf  [NI];
  logic          busy     [NI];
  logic [MW-1:0] out_sum  [NI];
  logic [63:0]   sum4;
  logic [15:0]   sum1;
  logic [111:0]  sum7;

  assign out_sum[0] = MW'(sum4);
  assign out_sum[1] = MW'(sum1);
  assign out_sum[2] = sum7;

  add_seq_ctrl #(.WORDS(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0][63:0]), .in_b(in_b[0][63:0]), .in_cin(in_cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(sum4),
    .out_cout(out_cout[0]), .out_ovf(out_ovf[0]), .busy(busy[0])
  );

  add_seq_ctrl #(.WORDS(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1][15:0]), .in_b(in_b[1][15:0]), .in_cin(in_cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum1),
    .out_cout(out_cout[1]), .out_ovf(out_ovf[1]), .busy(busy[1])
  );

  add_seq_ctrl #(.WORDS(7)) u_w7 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_cin(in_cin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(sum7),
    .out_cout(out_cout[2]), .out_ovf(out_ovf[2]), .busy(busy[2])
  );

  function automatic int wd(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 7);
  endfunction

  task automatic chk(input string nm, input int inst, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s w%0d got %h want %h at cycle %0d", nm, wd(inst), act, exp, cyc);
    end
  endtask

  // Reference: a + b + cin over DW bits, carry from bit DW, sign-rule overflow, optional clamp.
  task automatic model_calc(input int w, input logic [MW-1:0] a, input logic [MW-1:0] b, input logic cin,
                            output logic [MW-1:0] s, output logic c, output logic o);
    int dw;
    logic [MW:0] one, mask, full;
    dw   = w * 16;
    one  = 1;
    mask = (one << dw) - one;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (MW+1)'(cin);
    s    = MW'(full & mask);
    c    = full[dw];
    o    = (a[dw-1] == b[dw-1]) && (s[dw-1] != a[dw-1]);
`ifdef ADDSEQ_SAT_EN
    if (o) s = a[dw-1] ? MW'(one << (dw - 1)) : MW'(mask >> 1);
`endif
  endtask

  // Expected-result scoreboard: phase 0 idle, 1 computing, 2 result held.
  int            ph   [NI];
  int            left [NI];
  logic [MW-1:0] h_sum [NI];
  logic          h_cout[NI];
  logic          h_ovf [NI];
  logic [MW+1:0] exp_q [NI][$];

  always @(posedge clk) begin
    logic [MW-1:0] s;
    logic c, o;
    logic [MW+1:0] e;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        ph[i] = 0; left[i] = 0; h_sum[i] = '0; h_cout[i] = 1'b0; h_ovf[i] = 1'b0;
        exp_q[i].delete();
      end else begin
        case (ph[i])
          0: if (in_valid[i]) begin
            model_calc(wd(i), in_a[i], in_b[i], in_cin[i], s, c, o);
            exp_q[i].push_back({c, o, s});
            left[i] = wd(i);
            ph[i] = 1;
          end
          1: begin
            left[i]--;
            if (left[i] == 0) begin
              e = exp_q[i].pop_front();
              {h_cout[i], h_ovf[i], h_sum[i]} = e;
              ph[i] = 2;
            end
          end
          2: if (out_ready[i]) ph[i] = 0;
          default: ph[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk("in_ready",  i, MW'(in_ready[i]),  MW'(ph[i] == 0));
        chk("out_valid", i, MW'(out_valid[i]), MW'(ph[i] == 2));
        chk("busy",      i, MW'(busy[i]),      MW'(ph[i] != 0));
        chk("out_sum",   i, out_sum[i],        h_sum[i]);
        chk("out_cout",  i, MW'(out_cout[i]),  MW'(h_cout[i]));
        chk("out_ovf",   i, MW'(out_ovf[i]),   MW'(h_ovf[i]));
      end
    end
  end

  // Driver tasks: called and return at a falling edge.
  task automatic do_op(input int i, input logic [MW-1:0] a, input logic [MW-1:0] b, input logic cin,
                       output int t_acc);
    int n;
    in_a[i] = a; in_b[i] = b; in_cin[i] = cin; in_valid[i] = 1'b1;
    n = 0;
    while (!in_ready[i] && n < 200) begin @(negedge clk); n++; end
    if (!in_ready[i]) chk("in_ready_wait", i, MW'(in_ready[i]), MW'(1));
    @(negedge clk);
    in_valid[i] = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_valid(input int i);
    int n;
    n = 0;
    while (!out_valid[i] && n < 200) begin @(negedge clk); n++; end
    if (!out_valid[i]) chk("out_valid_wait", i, MW'(out_valid[i]), MW'(1));
  endtask

  task automatic get_res(input int i, input int t_acc, output logic [MW-1:0] s, output logic c,
                         output logic o, output int lat);
    wait_valid(i);
    s = out_sum[i]; c = out_cout[i]; o = out_ovf[i];
    lat = cyc - t_acc;
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
  endtask

  task automatic run_case(input string nm, input int i, input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input logic cin, input logic [MW-1:0] e_sum, input logic e_cout, input logic e_ovf);
    logic [MW-1:0] s, ms;
    logic c, o, mc, mo;
    int t, lat;
    model_calc(wd(i), a, b, cin, ms, mc, mo);
    chk({nm, "_model_sum"}, i, ms, e_sum);
    chk({nm, "_model_flags"}, i, MW'({mc, mo}), MW'({e_cout, e_ovf}));
    do_op(i, a, b, cin, t);
    get_res(i, t, s, c, o, lat);
    chk({nm, "_sum"}, i, s, e_sum);
    chk({nm, "_cout"}, i, MW'(c), MW'(e_cout));
    chk({nm, "_ovf"}, i, MW'(o), MW'(e_ovf));
    chk({nm, "_latency"}, i, MW'(lat), MW'(wd(i)));
  endtask

  function automatic logic [MW-1:0] rnd();
    logic [127:0] t;
    case ($urandom_range(0, 5))
      0: t = '1;
      1: t = '0;
      2: t = {4{32'h8000_0000}};
      default: t = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return t[MW-1:0];
  endfunction

  task automatic stream(input int i, input int nops);
    int prev, n, t;
    prev = -1;
    out_ready[i] = 1'b1;
    in_valid[i] = 1'b1;
    for (int k = 0; k < nops; k++) begin
      in_a[i] = rnd(); in_b[i] = rnd(); in_cin[i] = 1'($urandom_range(0, 1));
      n = 0;
      while (!in_ready[i] && n < 50) begin @(negedge clk); n++; end
      if (!in_ready[i]) begin
        chk("stream_ready", i, MW'(in_ready[i]), MW'(1));
        break;
      end
      @(negedge clk);
      t = cyc;
      if (prev >= 0) chk("period", i, MW'(t - prev), MW'(wd(i) + 2));
      prev = t;
    end
    in_valid[i] = 1'b0;
    repeat (wd(i) + 3) @(negedge clk);
    out_ready[i] = 1'b0;
  endtask

  initial begin
    logic [MW-1:0] s;
    logic c, o;
    int t, lat;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_cin[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready", 0, MW'(in_ready[0]), MW'(1));
    chk("rst_out_valid", 0, MW'(out_valid[0]), MW'(0));
    chk("rst_busy", 0, MW'(busy[0]), MW'(0));
    chk("rst_out_sum", 0, out_sum[0], MW'(0));
    rst = 1'b0;
    @(negedge clk);

    run_case("t1", 0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_case("t1w1", 1, 16'hFFFF, 16'h1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_case("t1w7", 2, 112'hFFFF, 112'h1, 1'b0, 112'h1_0000, 1'b0, 1'b0);
    run_case("t2", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
`ifdef ADDSEQ_SAT_EN
    run_case("t3pos", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_case("t3neg", 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
             64'h8000_0000_0000_0000, 1'b1, 1'b1);
`else
    run_case("t3pos", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_case("t3neg", 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
`endif

    // Result held while the consumer stalls; new operands must wait.
    do_op(0, 3, 4, 1'b0, t);
    wait_valid(0);
    in_a[0] = 100; in_b[0] = 200; in_cin[0] = 1'b0; in_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t4_in_ready", 0, MW'(in_ready[0]), MW'(0));
      chk("t4_out_valid", 0, MW'(out_valid[0]), MW'(1));
      chk("t4_sum_hold", 0, out_sum[0], MW'(7));
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("t4_idle_ready", 0, MW'(in_ready[0]), MW'(1));
    chk("t4_idle_valid", 0, MW'(out_valid[0]), MW'(0));
    out_ready[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    t = cyc;
    get_res(0, t, s, c, o, lat);
    chk("t4_new_sum", 0, s, MW'(300));
    chk("t4_new_latency", 0, MW'(lat), MW'(4));

    // Reset during the second compute cycle discards the operation.
    do_op(0, 64'h1234, 64'h1111, 1'b0, t);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", 0, MW'(in_ready[0]), MW'(1));
    chk("t5_out_valid", 0, MW'(out_valid[0]), MW'(0));
    chk("t5_out_sum", 0, out_sum[0], MW'(0));
    rst = 1'b0;
    @(negedge clk);
    run_case("t5", 0, 5, 7, 1'b0, 12, 1'b0, 1'b0);

    for (int i = 0; i < NI; i++) stream(i, 100);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
